// File: rtl/dll_norm_sched.sv
// Round-robin scheduler sharing one two-stage DLL priority encoder among
// NUM_CHAN discriminator channels; returns tagged, clamped MSB position and shift.
module dll_norm_sched #(
  parameter int NUM_CHAN  = 4,
  parameter int CHAN_BITS = 2,
  parameter int ENC_LAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CHAN-1:0]      req,
  input  logic [36*NUM_CHAN-1:0]   req_data,
  output logic [NUM_CHAN-1:0]      grant,
  output logic [35:0]              enc_in,
  input  logic [5:0]               enc_pos,
  output logic                     res_valid,
  output logic [CHAN_BITS-1:0]     res_chan,
  output logic [5:0]               res_pos,
  output logic [4:0]               res_shift,
  output logic                     res_err,
  output logic                     busy
);

  localparam logic [5:0] POS_MIN = 6'd10;
  localparam logic [5:0] POS_MAX = 6'd35;

  logic [CHAN_BITS-1:0]              rr;
  logic [CHAN_BITS-1:0]              win;
  logic                              win_vld;
  logic [CHAN_BITS-1:0]              rr_next;
  logic [ENC_LAT-1:0]                pipe_vld;
  logic [ENC_LAT-1:0][CHAN_BITS-1:0] pipe_chan;
  logic [5:0]                        pos_clamp;
  logic                              pos_bad;

  // First requester at or after rr wins; reset suppresses any grant.
  always_comb begin
    int unsigned idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      idx = 32'(rr) + i;
      if (idx >= NUM_CHAN) idx = idx - NUM_CHAN;
      if (!win_vld && req[CHAN_BITS'(idx)]) begin
        win_vld = 1'b1;
        win     = CHAN_BITS'(idx);
      end
    end
    if (reset) win_vld = 1'b0;
  end

  assign rr_next = (win == CHAN_BITS'(NUM_CHAN - 1)) ? '0 : win + 1'b1;

  always_comb begin
    grant = '0;
    if (win_vld) grant[win] = 1'b1;
  end

  always_comb begin
    enc_in = '0;
    for (int unsigned k = 0; k < NUM_CHAN; k++) begin
      enc_in = enc_in | ({36{grant[k]}} & req_data[36*k +: 36]);
    end
  end

  always_comb begin
    pos_bad   = (enc_pos < POS_MIN) || (enc_pos > POS_MAX);
    pos_clamp = enc_pos;
    if (enc_pos < POS_MIN) pos_clamp = POS_MIN;
    else if (enc_pos > POS_MAX) pos_clamp = POS_MAX;
  end

  // The res_* registers act as the final tag stage, aligned with enc_pos
  // arriving ENC_LAT cycles after issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr        <= '0;
      pipe_vld  <= '0;
      pipe_chan <= '0;
      res_valid <= 1'b0;
      res_chan  <= '0;
      res_pos   <= POS_MIN;
      res_shift <= '0;
      res_err   <= 1'b0;
    end else begin
      if (win_vld) rr <= rr_next;
      if (ENC_LAT > 1) begin
        pipe_vld  <= {pipe_vld[ENC_LAT-2:0], win_vld};
        pipe_chan <= {pipe_chan[ENC_LAT-2:0], win};
      end else begin
        pipe_vld  <= win_vld;
        pipe_chan <= win;
      end
      res_valid <= pipe_vld[ENC_LAT-1];
      res_err   <= pipe_vld[ENC_LAT-1] && pos_bad;
      if (pipe_vld[ENC_LAT-1]) begin
        res_chan  <= pipe_chan[ENC_LAT-1];
        res_pos   <= pos_clamp;
        res_shift <= 5'(pos_clamp - POS_MIN);
      end
    end
  end

  assign busy = (|req) || (|pipe_vld) || res_valid;

endmodule

// File: tb/tb_dll_norm_sched.sv
// Self-checking bench for dll_norm_sched: behavioural encoder, queue-based
// reference model, table-driven clamp vectors, directed and random sequences.
module tb_dll_norm_sched;
  localparam int NC = 4;
  localparam int CB = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   req;
  logic [36*NC-1:0] req_data;
  logic [NC-1:0]   grant;
  logic [35:0]     enc_in;
  logic [5:0]      enc_pos;
  logic            res_valid;
  logic [CB-1:0]   res_chan;
  logic [5:0]      res_pos;
  logic [4:0]      res_shift;
  logic            res_err;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dll_norm_sched #(.NUM_CHAN(NC), .CHAN_BITS(CB), .ENC_LAT(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
    .enc_in(enc_in), .enc_pos(enc_pos), .res_valid(res_valid), .res_chan(res_chan),
    .res_pos(res_pos), .res_shift(res_shift), .res_err(res_err), .busy(busy)
  );

  // MSB position of a magnitude as the real encoder reports it (floor of 10).
  function automatic int msb_pos(input logic [35:0] v);
    int p;
    p = 10;
    for (int i = 0; i < 36; i++) if (v[i]) p = i;
    if (p < 10) p = 10;
    return p;
  endfunction

  // Two-cycle encoder with an override hook for fault injection.
  logic [5:0] enc_s1, enc_s2;
  logic       fault_en;
  logic [5:0] fault_val;
  always @(posedge clk) begin
    enc_s1 <= 6'(msb_pos(enc_in));
    enc_s2 <= enc_s1;
  end
  assign enc_pos = fault_en ? fault_val : enc_s2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: result queue keyed by due cycle.
  typedef struct {
    int          due;
    int          chan;
    logic [35:0] data;
  } exp_t;
  exp_t q[$];
  int   cyc = 0;
  int   rr = 0;
  logic pf = 1'b0;
  logic [5:0] pfv = '0;
  int   last_chan = 0;
  int   last_pos = 10;

  always @(negedge clk) begin
    int g, raw, epos, c;
    bit eerr, ev;
    logic [NC-1:0] eg;
    logic [35:0] ein;
    exp_t e;
    g = -1;
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        c = (rr + i) % NC;
        if (g < 0 && req[c]) g = c;
      end
    end
    eg  = (g >= 0) ? (NC'(1) << g) : '0;
    ein = (g >= 0) ? req_data[36*g +: 36] : '0;
    chk("grant", 64'(grant), 64'(eg));
    chk("enc_in", 64'(enc_in), 64'(ein));

    ev = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e    = q.pop_front();
      ev   = 1'b1;
      raw  = pf ? int'(pfv) : msb_pos(e.data);
      eerr = (raw < 10) || (raw > 35);
      epos = (raw < 10) ? 10 : ((raw > 35) ? 35 : raw);
      chk("res_valid", 64'(res_valid), 64'(1));
      chk("res_chan", 64'(res_chan), 64'(e.chan));
      chk("res_pos", 64'(res_pos), 64'(epos));
      chk("res_shift", 64'(res_shift), 64'(epos - 10));
      chk("res_err", 64'(res_err), 64'(eerr));
      last_chan = e.chan;
      last_pos  = epos;
    end else begin
      chk("res_valid_idle", 64'(res_valid), 64'(0));
      chk("res_err_idle", 64'(res_err), 64'(0));
      chk("res_chan_hold", 64'(res_chan), 64'(last_chan));
      chk("res_pos_hold", 64'(res_pos), 64'(last_pos));
      chk("res_shift_hold", 64'(res_shift), 64'(last_pos - 10));
    end
    chk("busy", 64'(busy), 64'((req != '0) || (q.size() > 0) || ev));

    if (reset) begin
      q.delete();
      rr        = 0;
      last_chan = 0;
      last_pos  = 10;
    end else if (g >= 0) begin
      q.push_back('{cyc + 3, g, req_data[36*g +: 36]});
      rr = (g + 1) % NC;
    end
    pf  = fault_en;
    pfv = fault_val;
    cyc++;
  end

  typedef struct {
    logic [5:0] fv;
    int         pos;
    int         shift;
    bit         err;
  } fvec_t;
  fvec_t tbl[8];

  initial begin
    logic [NC-1:0] lastg;
    int zeros, found;
    tbl[0] = '{6'd3,  10, 0,  1'b1};
    tbl[1] = '{6'd40, 35, 25, 1'b1};
    tbl[2] = '{6'd10, 10, 0,  1'b0};
    tbl[3] = '{6'd35, 35, 25, 1'b0};
    tbl[4] = '{6'd9,  10, 0,  1'b1};
    tbl[5] = '{6'd36, 35, 25, 1'b1};
    tbl[6] = '{6'd0,  10, 0,  1'b1};
    tbl[7] = '{6'd22, 22, 12, 1'b0};

    reset = 1'b1; req = '0; req_data = '0; fault_en = 1'b0; fault_val = '0;
    repeat (3) step();
    chk("rst_valid", 64'(res_valid), 64'(0));
    chk("rst_chan", 64'(res_chan), 64'(0));
    chk("rst_pos", 64'(res_pos), 64'(10));
    chk("rst_shift", 64'(res_shift), 64'(0));
    chk("rst_err", 64'(res_err), 64'(0));
    reset = 1'b0;

    // Single request on channel 2.
    repeat (5) step();
    req[2] = 1'b1; req_data[72 +: 36] = 36'h0_0000_0800;
    #1;
    chk("single_grant", 64'(grant), 64'(4'b0100));
    chk("single_enc_in", 64'(enc_in), 64'(36'h800));
    step(); req = '0;
    step(); step();
    chk("single_valid", 64'(res_valid), 64'(1));
    chk("single_chan", 64'(res_chan), 64'(2));
    chk("single_pos", 64'(res_pos), 64'(11));
    chk("single_shift", 64'(res_shift), 64'(1));
    step();

    // All channels requesting from reset release; grant in the first free cycle.
    reset = 1'b1; req = '1;
    for (int k = 0; k < NC; k++) req_data[36*k +: 36] = 36'h8_0000_0000 >> k;
    #1;
    chk("rst_grant_blocked", 64'(grant), 64'(0));
    chk("rst_enc_in_zero", 64'(enc_in), 64'(0));
    step(); reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("rr_grant", 64'(grant), 64'(4'b0001 << (i % 4)));
      if (i >= 3) begin
        chk("stream_valid", 64'(res_valid), 64'(1));
        chk("stream_pos", 64'(res_pos), 64'(35 - ((i - 3) % 4)));
      end
      step();
    end
    req = '0;
    repeat (4) step();

    // Small magnitude on channel 1.
    req[1] = 1'b1; req_data[36 +: 36] = 36'd5;
    step(); req = '0;
    step(); step();
    chk("small_valid", 64'(res_valid), 64'(1));
    chk("small_chan", 64'(res_chan), 64'(1));
    chk("small_pos", 64'(res_pos), 64'(10));
    chk("small_shift", 64'(res_shift), 64'(0));
    chk("small_err", 64'(res_err), 64'(0));
    step();

    // Fairness: channel 0 held, channel 3 joins in cycle 2.
    reset = 1'b1; step(); reset = 1'b0;
    req[0] = 1'b1; req_data[0 +: 36] = 36'h1_0000;
    step(); step();
    req[3] = 1'b1; req_data[108 +: 36] = 36'h2_0000;
    zeros = 0; found = 0;
    for (int j = 0; j < 4 && found == 0; j++) begin
      #1;
      if (grant[3]) found = 1;
      else if (grant[0]) zeros++;
      step();
    end
    chk("fair_grant3_seen", 64'(found), 64'(1));
    chk("fair_ch0_before_ch3_le1", 64'(zeros <= 1), 64'(1));
    req[3] = 1'b0;
    #1;
    chk("fair_back_to_ch0", 64'(grant), 64'(4'b0001));
    step(); req = '0;
    repeat (4) step();

    // Reset mid-flight: issue in cycle 4, reset in cycles 5..6.
    reset = 1'b1; step(); reset = 1'b0;
    repeat (4) step();
    req[1] = 1'b1; req_data[36 +: 36] = 36'h0_0010_0000;
    step();
    reset = 1'b1; req = '1;
    for (int c = 5; c <= 12; c++) begin
      #1;
      if (c == 7) begin reset = 1'b0; req = '0; #1; end
      if (c <= 6) begin
        chk("midrst_grant", 64'(grant), 64'(0));
        chk("midrst_enc_in", 64'(enc_in), 64'(0));
      end
      chk("midrst_no_valid", 64'(res_valid), 64'(0));
      if (c >= 6) chk("midrst_pos_rst", 64'(res_pos), 64'(10));
      step();
    end

    // Encoder fault vectors on channel 1.
    for (int v = 0; v < 8; v++) begin
      req[1] = 1'b1; req_data[36 +: 36] = 36'h0_0000_4000;
      step(); req = '0;
      step(); fault_en = 1'b1; fault_val = tbl[v].fv;
      step(); fault_en = 1'b0;
      chk("fault_valid", 64'(res_valid), 64'(1));
      chk("fault_pos", 64'(res_pos), 64'(tbl[v].pos));
      chk("fault_shift", 64'(res_shift), 64'(tbl[v].shift));
      chk("fault_err", 64'(res_err), 64'(tbl[v].err));
      step();
      chk("fault_err_one_cycle", 64'(res_err), 64'(0));
      chk("fault_pos_hold", 64'(res_pos), 64'(tbl[v].pos));
    end

    // Random traffic, faults and occasional resets against the model.
    lastg = '0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NC; k++) begin
        if (!req[k] || lastg[k]) begin
          req[k] = ($urandom_range(0, 2) != 0);
          req_data[36*k +: 36] = 36'({$urandom, $urandom} >> $urandom_range(0, 40));
        end else if ($urandom_range(0, 9) == 0) begin
          req[k] = 1'b0;
        end
      end
      fault_en  = ($urandom_range(0, 15) == 0);
      fault_val = 6'($urandom);
      #3;
      lastg = grant;
      step();
    end
    req = '0; reset = 1'b0; fault_en = 1'b0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
